// File: rtl/execute_units.sv
// Execute stage: two single-cycle ALU/multiply/address lanes plus a shared
// iterative radix-2 divider with its own result port and speculative flush.
package execute_units_pkg;
  typedef logic [5:0] tag_t;
  typedef logic [3:0] spectag_t;
  typedef enum logic [1:0] {UNIT_ALU, UNIT_LOAD, UNIT_STORE, UNIT_BRANCH} unit_t;
  typedef enum logic {EX_NORMAL, EX_GEN_ADDR} ex_mode_t;
  typedef struct packed {
    logic        is_valid;
    unit_t       Unit;
    ex_mode_t    mode;
    logic [2:0]  rm;
    spectag_t    speculative_tag;
    logic [9:0]  Op;
    logic [31:0] Vj;
    logic [31:0] Vk;
    logic [31:0] A;
    logic [31:0] pc;
    tag_t        tag;
  } ex_content_t;
endpackage

module execute_units
  import execute_units_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  ex_content_t ex_contents [2],
  input  logic        flush_valid,
  input  spectag_t    flush_mask,
  output logic [1:0]  res_valid,
  output tag_t        res_tag   [2],
  output logic [31:0] res_value [2],
  output ex_mode_t    res_mode  [2],
  output logic        div_valid,
  output tag_t        div_tag,
  output logic [31:0] div_value,
  output logic        div_busy
);

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

  function automatic logic [31:0] lane_compute(input ex_content_t p);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] res;
    f3    = p.Op[2:0];
    f7    = p.Op[9:3];
    // Low 64 bits of the product of sign/zero-extended operands give every MULH variant.
    a_ext = (f3 == 3'd1 || f3 == 3'd2) ? {{32{p.Vj[31]}}, p.Vj} : {32'd0, p.Vj};
    b_ext = (f3 == 3'd1) ? {{32{p.Vk[31]}}, p.Vk} : {32'd0, p.Vk};
    prod  = a_ext * b_ext;
    res   = p.Vj + p.Vk;
    if (p.mode == EX_NORMAL && p.Unit == UNIT_ALU) begin
      if (f7 == 7'b0000001) begin
        res = (f3 == 3'd0) ? prod[31:0] : prod[63:32];
      end else begin
        unique case (f3)
          3'd0: res = f7[5] ? (p.Vj - p.Vk) : (p.Vj + p.Vk);
          3'd1: res = p.Vj << p.Vk[4:0];
          3'd2: res = {31'd0, $signed(p.Vj) < $signed(p.Vk)};
          3'd3: res = {31'd0, p.Vj < p.Vk};
          3'd4: res = p.Vj ^ p.Vk;
          3'd5: res = f7[5] ? 32'($signed(p.Vj) >>> p.Vk[4:0]) : (p.Vj >> p.Vk[4:0]);
          3'd6: res = p.Vj | p.Vk;
          default: res = p.Vj & p.Vk;
        endcase
      end
    end
    return res;
  endfunction

  logic [1:0]  w_kill;
  logic [1:0]  w_is_div;
  logic [1:0]  w_lane_ok;
  logic [31:0] w_lane_res [2];

  always_comb begin
    w_kill    = '0;
    w_is_div  = '0;
    w_lane_ok = '0;
    for (int unsigned l = 0; l < 2; l++) begin
      w_kill[l]     = flush_valid && (|(ex_contents[l].speculative_tag & flush_mask));
      w_is_div[l]   = (ex_contents[l].Unit == UNIT_ALU) && (ex_contents[l].mode == EX_NORMAL) &&
                      (ex_contents[l].Op[9:3] == 7'b0000001) && ex_contents[l].Op[2];
      w_lane_ok[l]  = ex_contents[l].is_valid && !w_kill[l];
      w_lane_res[l] = lane_compute(ex_contents[l]);
    end
  end

  logic [1:0]  r_res_valid;
  tag_t        r_res_tag   [2];
  logic [31:0] r_res_value [2];
  ex_mode_t    r_res_mode  [2];
  spectag_t    r_res_spec  [2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_valid <= '0;
      for (int unsigned l = 0; l < 2; l++) begin
        r_res_tag[l]   <= '0;
        r_res_value[l] <= '0;
        r_res_mode[l]  <= EX_NORMAL;
        r_res_spec[l]  <= '0;
      end
    end else begin
      for (int unsigned l = 0; l < 2; l++) begin
        r_res_valid[l] <= w_lane_ok[l] && !w_is_div[l];
        r_res_tag[l]   <= ex_contents[l].tag;
        r_res_value[l] <= w_lane_res[l];
        r_res_mode[l]  <= ex_contents[l].mode;
        r_res_spec[l]  <= ex_contents[l].speculative_tag;
      end
    end
  end

  // A held result whose tag is being killed is hidden while the flush is asserted.
  always_comb begin
    for (int unsigned l = 0; l < 2; l++) begin
      res_valid[l] = r_res_valid[l] && !(flush_valid && (|(r_res_spec[l] & flush_mask)));
      res_tag[l]   = r_res_tag[l];
      res_value[l] = r_res_value[l];
      res_mode[l]  = r_res_mode[l];
    end
  end

  div_state_t  r_div_state;
  div_state_t  w_div_next;
  logic [5:0]  r_div_cnt;
  logic [31:0] r_div_dvd;
  logic [31:0] r_div_dsr;
  logic [31:0] r_div_quot;
  logic [31:0] r_div_rem;
  logic [31:0] r_div_orig;
  logic        r_div_neg_q;
  logic        r_div_neg_r;
  logic        r_div_is_rem;
  logic        r_div_by_zero;
  spectag_t    r_div_spec;
  tag_t        r_div_tag_q;
  tag_t        r_div_tag;
  logic [31:0] r_div_value;

  logic        w_div_start;
  logic        w_div_kill;
  logic        w_div_signed;
  ex_content_t w_div_pkt;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [31:0] w_div_result;

  always_comb begin
    w_div_pkt    = w_lane_ok[0] && w_is_div[0] ? ex_contents[0] : ex_contents[1];
    w_div_start  = (r_div_state == DIV_IDLE) &&
                   ((w_lane_ok[0] && w_is_div[0]) || (w_lane_ok[1] && w_is_div[1]));
    w_div_signed = !w_div_pkt.Op[0];
    w_div_kill   = flush_valid && (|(r_div_spec & flush_mask)) && (r_div_state != DIV_IDLE);
    w_div_shift  = {r_div_rem, r_div_dvd[31]};
    w_div_ge     = w_div_shift >= {1'b0, r_div_dsr};
    if (r_div_by_zero)
      w_div_result = r_div_is_rem ? r_div_orig : '1;
    else if (r_div_is_rem)
      w_div_result = r_div_neg_r ? (32'd0 - r_div_rem) : r_div_rem;
    else
      w_div_result = r_div_neg_q ? (32'd0 - r_div_quot) : r_div_quot;
  end

  always_comb begin
    w_div_next = r_div_state;
    unique case (r_div_state)
      DIV_IDLE: if (w_div_start) w_div_next = DIV_RUN;
      DIV_RUN:  if (w_div_kill) w_div_next = DIV_IDLE;
                else if (r_div_cnt == 6'd32) w_div_next = DIV_DONE;
      DIV_DONE: w_div_next = DIV_IDLE;
      default:  w_div_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_div_state <= DIV_IDLE;
    else        r_div_state <= w_div_next;
  end

  // RUN takes 33 cycles: 32 restoring steps, then a sign/special-case fixup.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt     <= '0;
      r_div_dvd     <= '0;
      r_div_dsr     <= '0;
      r_div_quot    <= '0;
      r_div_rem     <= '0;
      r_div_orig    <= '0;
      r_div_neg_q   <= 1'b0;
      r_div_neg_r   <= 1'b0;
      r_div_is_rem  <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_div_spec    <= '0;
      r_div_tag_q   <= '0;
      r_div_tag     <= '0;
      r_div_value   <= '0;
    end else if (w_div_start) begin
      r_div_cnt     <= '0;
      r_div_dvd     <= (w_div_signed && w_div_pkt.Vj[31]) ? (32'd0 - w_div_pkt.Vj) : w_div_pkt.Vj;
      r_div_dsr     <= (w_div_signed && w_div_pkt.Vk[31]) ? (32'd0 - w_div_pkt.Vk) : w_div_pkt.Vk;
      r_div_quot    <= '0;
      r_div_rem     <= '0;
      r_div_orig    <= w_div_pkt.Vj;
      r_div_neg_q   <= w_div_signed && (w_div_pkt.Vj[31] ^ w_div_pkt.Vk[31]);
      r_div_neg_r   <= w_div_signed && w_div_pkt.Vj[31];
      r_div_is_rem  <= w_div_pkt.Op[1];
      r_div_by_zero <= (w_div_pkt.Vk == 32'd0);
      r_div_spec    <= w_div_pkt.speculative_tag;
      r_div_tag_q   <= w_div_pkt.tag;
    end else if (r_div_state == DIV_RUN && !w_div_kill) begin
      if (r_div_cnt == 6'd32) begin
        r_div_value <= w_div_result;
        r_div_tag   <= r_div_tag_q;
      end else begin
        r_div_rem  <= w_div_ge ? 32'(w_div_shift - {1'b0, r_div_dsr}) : w_div_shift[31:0];
        r_div_quot <= {r_div_quot[30:0], w_div_ge};
        r_div_dvd  <= {r_div_dvd[30:0], 1'b0};
        r_div_cnt  <= r_div_cnt + 6'd1;
      end
    end
  end

  assign div_busy  = (r_div_state != DIV_IDLE);
  assign div_valid = (r_div_state == DIV_DONE) && !w_div_kill;
  assign div_tag   = r_div_tag;
  assign div_value = r_div_value;

endmodule

// File: tb/tb_execute_units.sv
// Directed self-checking bench for execute_units: lane ops, divider timing,
// divide special cases, flush and mid-divide reset.
module tb_execute_units;
  import execute_units_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  ex_content_t ex [2];
  logic        flush_valid;
  spectag_t    flush_mask;
  logic [1:0]  res_valid;
  tag_t        res_tag   [2];
  logic [31:0] res_value [2];
  ex_mode_t    res_mode  [2];
  logic        div_valid;
  tag_t        div_tag;
  logic [31:0] div_value;
  logic        div_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  execute_units dut (
    .clk(clk), .rst_n(rst_n), .ex_contents(ex),
    .flush_valid(flush_valid), .flush_mask(flush_mask),
    .res_valid(res_valid), .res_tag(res_tag), .res_value(res_value), .res_mode(res_mode),
    .div_valid(div_valid), .div_tag(div_tag), .div_value(div_value), .div_busy(div_busy)
  );

  localparam logic [6:0] F7_M   = 7'b0000001;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic ex_content_t mk(input unit_t u, input ex_mode_t m, input logic [6:0] f7,
                                     input logic [2:0] f3, input logic [31:0] vj,
                                     input logic [31:0] vk, input tag_t t, input spectag_t s);
    ex_content_t p;
    p = '0;
    p.is_valid = 1'b1;
    p.Unit = u;
    p.mode = m;
    p.Op = {f7, f3};
    p.Vj = vj;
    p.Vk = vk;
    p.tag = t;
    p.speculative_tag = s;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex[0] = '0;
    ex[1] = '0;
  endtask

  // Issue a divide on lane 0 and follow it through to IDLE; also present a
  // second divide while in DONE, which must not be accepted.
  task automatic run_div(input string name, input logic [2:0] f3, input logic [31:0] vj,
                         input logic [31:0] vk, input tag_t t, input logic [31:0] exp);
    ex[0] = mk(UNIT_ALU, EX_NORMAL, F7_M, f3, vj, vk, t, 4'b0000);
    for (int k = 1; k <= 35; k++) begin
      step();
      if (k == 1) begin
        idle_inputs();
        check({name, "_lane_quiet"}, {30'd0, res_valid}, 32'd0);
      end
      check({name, "_busy"}, {31'd0, div_busy}, {31'd0, k <= 34});
      check({name, "_valid"}, {31'd0, div_valid}, {31'd0, k == 34});
      if (k == 34) begin
        check({name, "_value"}, div_value, exp);
        check({name, "_tag"}, {26'd0, div_tag}, {26'd0, t});
        ex[0] = mk(UNIT_ALU, EX_NORMAL, F7_M, 3'd4, 32'd9, 32'd3, 6'd1, 4'b0000);
      end
      if (k == 35) idle_inputs();
    end
  endtask

  initial begin
    logic stale;
    rst_n = 1'b0;
    flush_valid = 1'b0;
    flush_mask = '0;
    idle_inputs();
    step();
    step();
    check("rst_res_valid", {30'd0, res_valid}, 32'd0);
    check("rst_div_valid", {31'd0, div_valid}, 32'd0);
    check("rst_div_busy", {31'd0, div_busy}, 32'd0);
    check("rst_res_value0", res_value[0], 32'd0);
    check("rst_div_value", div_value, 32'd0);
    rst_n = 1'b1;

    // ADD wraps, address generation on lane 1
    ex[0] = mk(UNIT_ALU, EX_NORMAL, 7'd0, 3'd0, 32'd5, 32'hFFFF_FFFD, 6'd3, 4'b0000);
    ex[1] = mk(UNIT_ALU, EX_GEN_ADDR, 7'd0, 3'd0, 32'h1000, 32'h24, 6'd4, 4'b0000);
    step();
    check("add_valid", {30'd0, res_valid}, 32'd3);
    check("add_value", res_value[0], 32'd2);
    check("addr_value", res_value[1], 32'h1024);
    check("add_mode", {31'd0, res_mode[0]}, {31'd0, EX_NORMAL});
    check("addr_mode", {31'd0, res_mode[1]}, {31'd0, EX_GEN_ADDR});
    check("add_tag", {26'd0, res_tag[0]}, 32'd3);
    check("addr_tag", {26'd0, res_tag[1]}, 32'd4);

    ex[0] = mk(UNIT_ALU, EX_NORMAL, F7_ALT, 3'd0, 32'd3, 32'd5, 6'd0, 4'b0000);
    ex[1] = mk(UNIT_ALU, EX_NORMAL, F7_ALT, 3'd5, 32'h8000_0000, 32'd4, 6'd0, 4'b0000);
    step();
    check("sub", res_value[0], 32'hFFFF_FFFE);
    check("sra", res_value[1], 32'hF800_0000);

    ex[0] = mk(UNIT_ALU, EX_NORMAL, 7'd0, 3'd2, 32'hFFFF_FFFF, 32'd1, 6'd0, 4'b0000);
    ex[1] = mk(UNIT_ALU, EX_NORMAL, 7'd0, 3'd3, 32'hFFFF_FFFF, 32'd1, 6'd0, 4'b0000);
    step();
    check("slt", res_value[0], 32'd1);
    check("sltu", res_value[1], 32'd0);

    ex[0] = mk(UNIT_ALU, EX_NORMAL, 7'd0, 3'd1, 32'd1, 32'h3F, 6'd0, 4'b0000);
    ex[1] = mk(UNIT_ALU, EX_NORMAL, 7'd0, 3'd5, 32'h8000_0000, 32'd31, 6'd0, 4'b0000);
    step();
    check("sll_shamt5", res_value[0], 32'h8000_0000);
    check("srl", res_value[1], 32'd1);

    ex[0] = mk(UNIT_ALU, EX_NORMAL, F7_M, 3'd1, 32'h8000_0000, 32'h8000_0000, 6'd0, 4'b0000);
    ex[1] = mk(UNIT_ALU, EX_NORMAL, F7_M, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0, 4'b0000);
    step();
    check("mulh", res_value[0], 32'h4000_0000);
    check("mulhu", res_value[1], 32'hFFFF_FFFE);

    ex[0] = mk(UNIT_ALU, EX_NORMAL, F7_M, 3'd0, 32'd7, 32'd6, 6'd0, 4'b0000);
    ex[1] = mk(UNIT_ALU, EX_NORMAL, F7_M, 3'd2, 32'hFFFF_FFFF, 32'd2, 6'd0, 4'b0000);
    step();
    check("mul", res_value[0], 32'd42);
    check("mulhsu", res_value[1], 32'hFFFF_FFFF);

    ex[0] = mk(UNIT_LOAD, EX_NORMAL, 7'd0, 3'd2, 32'h100, 32'h8, 6'd9, 4'b0000);
    ex[1] = '0;
    step();
    check("load_pass", res_value[0], 32'h108);
    check("load_valid", {30'd0, res_valid}, 32'd1);

    idle_inputs();
    step();
    check("invalid_quiet", {30'd0, res_valid}, 32'd0);

    // incoming packet kill on lane 0 only
    ex[0] = mk(UNIT_ALU, EX_NORMAL, 7'd0, 3'd0, 32'd1, 32'd1, 6'd0, 4'b0100);
    ex[1] = mk(UNIT_ALU, EX_NORMAL, 7'd0, 3'd0, 32'd1, 32'd2, 6'd0, 4'b0001);
    flush_valid = 1'b1;
    flush_mask = 4'b0100;
    step();
    flush_valid = 1'b0;
    check("flush_in_valid", {30'd0, res_valid}, 32'd2);

    // registered result hidden while its tag is flushed
    ex[0] = mk(UNIT_ALU, EX_NORMAL, 7'd0, 3'd0, 32'd1, 32'd1, 6'd0, 4'b1000);
    ex[1] = '0;
    step();
    idle_inputs();
    check("held_valid", {30'd0, res_valid}, 32'd1);
    flush_valid = 1'b1;
    flush_mask = 4'b1000;
    #1;
    check("held_flushed", {30'd0, res_valid}, 32'd0);
    flush_valid = 1'b0;
    flush_mask = '0;

    run_div("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 6'd5, 32'hFFFF_FFFD);
    run_div("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 6'd6, 32'hFFFF_FFFF);
    run_div("divu_zero", 3'd5, 32'd1234, 32'd0, 6'd7, 32'hFFFF_FFFF);
    run_div("remu_zero", 3'd7, 32'd1234, 32'd0, 6'd8, 32'd1234);
    run_div("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 6'd9, 32'h8000_0000);
    run_div("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 6'd10, 32'd0);

    // speculative divide killed at cycle 10
    ex[0] = mk(UNIT_ALU, EX_NORMAL, F7_M, 3'd4, 32'd100, 32'd7, 6'd11, 4'b0010);
    for (int k = 1; k <= 10; k++) begin
      step();
      idle_inputs();
    end
    check("flush_busy_before", {31'd0, div_busy}, 32'd1);
    flush_valid = 1'b1;
    flush_mask = 4'b0010;
    step();
    flush_valid = 1'b0;
    flush_mask = '0;
    check("flush_busy_after", {31'd0, div_busy}, 32'd0);
    check("flush_no_valid", {31'd0, div_valid}, 32'd0);
    run_div("div_after_flush", 3'd4, 32'd20, 32'd3, 6'd12, 32'd6);

    // reset mid-divide
    ex[0] = mk(UNIT_ALU, EX_NORMAL, F7_M, 3'd4, 32'd1000, 32'd3, 6'd13, 4'b0000);
    ex[1] = mk(UNIT_ALU, EX_NORMAL, 7'd0, 3'd0, 32'd1, 32'd1, 6'd1, 4'b0000);
    step();
    idle_inputs();
    for (int k = 2; k <= 16; k++) step();
    ex[1] = mk(UNIT_ALU, EX_NORMAL, 7'd0, 3'd0, 32'd1, 32'd1, 6'd1, 4'b0000);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle_inputs();
    check("mid_rst_res_valid", {30'd0, res_valid}, 32'd0);
    check("mid_rst_div_valid", {31'd0, div_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, div_busy}, 32'd0);
    check("mid_rst_div_value", div_value, 32'd0);
    stale = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      stale = stale | div_valid | div_busy;
    end
    check("no_stale_div", {31'd0, stale}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
